digit_entry_reg: RTL and testbench
==================================

DIGIT_ENTRY_REG -- requirements
Module: digit_entry_reg

Interface
REQ-001 The block SHALL have parameter DIGIT_W, default 4, bits per entered digit.
REQ-002 The block SHALL have parameter DIGITS, default 8, number of digit slots held.
REQ-003 The block SHALL have parameter FULL_MODE, default 0, enter-when-full policy (0 = drop oldest, 1 = reject).
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port enter, input, 1, push the current digit.
REQ-007 The block SHALL have port backspace, input, 1, remove the most recently entered digit.
REQ-008 The block SHALL have port clear, input, 1, synchronous clear of all digits.
REQ-009 The block SHALL have port digit, input, DIGIT_W, digit value sampled on an accepted enter.
REQ-010 The block SHALL have port value, output, DIGITS*DIGIT_W, packed digits; newest digit in bits [DIGIT_W-1:0].
REQ-011 The block SHALL have port count, output, $clog2(DIGITS+1), number of valid digits held.
REQ-012 The block SHALL have port full, output, 1, high when count == DIGITS.
REQ-013 The block SHALL have port empty, output, 1, high when count == 0.
REQ-014 The block SHALL have port overflow, output, 1, one-cycle pulse on enter while full.

Function
REQ-015 All outputs SHALL be registered or decoded only from registered state; no input-to-output combinational path.
REQ-016 Command priority per cycle SHALL be clear > enter > backspace; lower-priority commands in the same cycle are discarded.
REQ-017 Clear SHALL set value to 0 and count to 0 in the next cycle, and SHALL not pulse overflow.
REQ-018 Enter with count < DIGITS SHALL shift value left by DIGIT_W, load digit into the low slot, and increment count; latency one cycle.
REQ-019 Enter with count == DIGITS and FULL_MODE = 0 SHALL shift and load as in REQ-018, discard the oldest digit, hold count at DIGITS, and pulse overflow.
REQ-020 Enter with count == DIGITS and FULL_MODE = 1 SHALL leave value and count unchanged and pulse overflow.
REQ-021 Backspace with count > 0 SHALL shift value right by DIGIT_W, fill the top slot with 0, and decrement count.
REQ-022 Backspace with count == 0 SHALL be a no-op: value, count and overflow unchanged or low.
REQ-023 Slots at or above index count SHALL always read 0 in value.
REQ-024 With no command active, all state SHALL hold.
REQ-025 Overflow SHALL be high for exactly one cycle per rejected or dropping enter, and low otherwise.

Reset
REQ-026 Assertion of reset_n low SHALL immediately force value = 0, count = 0, overflow = 0, empty = 1, full = 0, regardless of clk.
REQ-027 Reset SHALL also clear the edge-detect history registers when present (REQ-029).
REQ-028 Commands on the first rising clk edge after reset_n deasserts SHALL be processed normally.

Configuration
REQ-029 With macro DIGIT_ENTRY_EDGE_EN defined, enter, backspace and clear SHALL be rising-edge detected internally: a held-high input SHALL act once, in the cycle it is first sampled high; latency from input rise to state change is one cycle.
REQ-030 Without DIGIT_ENTRY_EDGE_EN, enter, backspace and clear SHALL be level commands: each cycle sampled high SHALL act once.

Verification
REQ-031 Default parameters; enter digits 1,2,3 -> value = 0x00000123, count = 3, empty = 0, full = 0.
REQ-032 FULL_MODE = 0; enter 1..8 then 9 -> value = 0x23456789, count = 8, full = 1, overflow high for one cycle only.
REQ-033 FULL_MODE = 1; enter 1..8 then 9 -> value = 0x12345678, count = 8, overflow pulsed once.
REQ-034 Value 0x00000123; backspace twice, then backspace with enter and digit 7 in the same cycle -> value 0x00000001, then 0x00000017, count = 2.
REQ-035 Clear, enter and backspace in the same cycle with value 0x00000045 -> value = 0, count = 0; then backspace at empty -> no change, overflow low.
REQ-036 reset_n pulsed low between clk edges with count = 5 -> outputs reset within that low phase; with DIGIT_ENTRY_EDGE_EN, enter held high for 4 cycles -> count increments by exactly 1.

Source files
------------

// File: rtl/digit_entry_reg_if.sv
// Command bundle for digit_entry_reg: enter/backspace/clear strobes and digit.
// The driver side uses master, the register side uses slave.
interface digit_entry_reg_if #(
  parameter int DIGIT_W = 4
) ();
  logic               enter;
  logic               backspace;
  logic               clear;
  logic [DIGIT_W-1:0] digit;

  modport master (
    output enter,
    output backspace,
    output clear,
    output digit
  );

  modport slave (
    input enter,
    input backspace,
    input clear,
    input digit
  );
endinterface

// File: rtl/digit_entry_reg.sv
// Digit entry shift register: newest digit in the low slot, backspace, clear.
// Define DIGIT_ENTRY_EDGE_EN to make enter/backspace/clear rising-edge commands.
module digit_entry_reg #(
  parameter int DIGIT_W   = 4,
  parameter int DIGITS    = 8,
  parameter int FULL_MODE = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enter,
  input  logic                         backspace,
  input  logic                         clear,
  input  logic [DIGIT_W-1:0]           digit,
  output logic [DIGITS*DIGIT_W-1:0]    value,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);

  localparam int VW = DIGITS * DIGIT_W;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] MAXC = CW'(DIGITS);

  logic [VW-1:0] r_value;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic [VW-1:0] w_value_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_ovf_nxt;
  logic [VW-1:0] w_shl;
  logic          w_enter;
  logic          w_bksp;
  logic          w_clr;

`ifdef DIGIT_ENTRY_EDGE_EN
  logic r_enter_d;
  logic r_bksp_d;
  logic r_clr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enter_d <= 1'b0;
      r_bksp_d  <= 1'b0;
      r_clr_d   <= 1'b0;
    end else begin
      r_enter_d <= enter;
      r_bksp_d  <= backspace;
      r_clr_d   <= clear;
    end
  end

  assign w_enter = enter & ~r_enter_d;
  assign w_bksp  = backspace & ~r_bksp_d;
  assign w_clr   = clear & ~r_clr_d;
`else
  assign w_enter = enter;
  assign w_bksp  = backspace;
  assign w_clr   = clear;
`endif

  // Shift-in of zeros keeps every slot at or above count reading 0.
  assign w_shl = (r_value << DIGIT_W) | VW'(digit);

  always_comb begin
    w_value_nxt = r_value;
    w_count_nxt = r_count;
    w_ovf_nxt   = 1'b0;
    if (w_clr) begin
      w_value_nxt = '0;
      w_count_nxt = '0;
    end else if (w_enter) begin
      if (r_count != MAXC) begin
        w_value_nxt = w_shl;
        w_count_nxt = r_count + CW'(1);
      end else begin
        w_ovf_nxt = 1'b1;
        if (FULL_MODE == 0) begin
          w_value_nxt = w_shl;
        end
      end
    end else if (w_bksp && (r_count != '0)) begin
      w_value_nxt = r_value >> DIGIT_W;
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_value <= w_value_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign value    = r_value;
  assign count    = r_count;
  assign full     = (r_count == MAXC);
  assign empty    = (r_count == '0);
  assign overflow = r_ovf;

endmodule

// File: tb/tb_digit_entry_reg.sv
// Bench for digit_entry_reg: drop-oldest and reject instances on one command bus,
// queue-based model checked every cycle plus hand-computed literal checks.
module tb_digit_entry_reg;

  logic clk;
  logic reset_n;
  bit   run;
  int   nchk;
  int   nerr;

  digit_entry_reg_if #(.DIGIT_W(4)) cif ();

  logic [31:0] val0, val1;
  logic [3:0]  cnt0, cnt1;
  logic        full0, full1, emp0, emp1, ovf0, ovf1;

  digit_entry_reg #(.DIGIT_W(4), .DIGITS(8), .FULL_MODE(0)) u_drop (
    .clk(clk), .reset_n(reset_n),
    .enter(cif.enter), .backspace(cif.backspace),
    .clear(cif.clear), .digit(cif.digit),
    .value(val0), .count(cnt0), .full(full0),
    .empty(emp0), .overflow(ovf0)
  );

  digit_entry_reg #(.DIGIT_W(4), .DIGITS(8), .FULL_MODE(1)) u_rej (
    .clk(clk), .reset_n(reset_n),
    .enter(cif.enter), .backspace(cif.backspace),
    .clear(cif.clear), .digit(cif.digit),
    .value(val1), .count(cnt1), .full(full1),
    .empty(emp1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: digits oldest-first in a queue; overflow flag per instance.
  int q0[$];
  int q1[$];
  bit mo0, mo1;
  bit pe, pb, pc;

  function automatic logic [31:0] qval(input int qq[$]);
    logic [31:0] v;
    v = 32'h0;
    foreach (qq[i]) v = (v << 4) | 32'(qq[i]);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    q0.delete();
    q1.delete();
    mo0 = 0; mo1 = 0;
    pe = 0; pb = 0; pc = 0;
  endtask

  task automatic mdl_clk(input bit e, input bit b, input bit c, input int d);
    bit ee, eb, ec;
`ifdef DIGIT_ENTRY_EDGE_EN
    ee = e && !pe; eb = b && !pb; ec = c && !pc;
    pe = e; pb = b; pc = c;
`else
    ee = e; eb = b; ec = c;
`endif
    mo0 = 0; mo1 = 0;
    if (ec) begin
      q0.delete();
      q1.delete();
    end else if (ee) begin
      if (q0.size() < 8) q0.push_back(d);
      else begin
        void'(q0.pop_front());
        q0.push_back(d);
        mo0 = 1;
      end
      if (q1.size() < 8) q1.push_back(d);
      else mo1 = 1;
    end else if (eb) begin
      if (q0.size() > 0) void'(q0.pop_back());
      if (q1.size() > 0) void'(q1.pop_back());
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("m0.value", 64'(val0), 64'(qval(q0)));
      chk("m0.count", 64'(cnt0), 64'(q0.size()));
      chk("m0.full", 64'(full0), 64'(q0.size() == 8));
      chk("m0.empty", 64'(emp0), 64'(q0.size() == 0));
      chk("m0.ovf", 64'(ovf0), 64'(mo0));
      chk("m1.value", 64'(val1), 64'(qval(q1)));
      chk("m1.count", 64'(cnt1), 64'(q1.size()));
      chk("m1.full", 64'(full1), 64'(q1.size() == 8));
      chk("m1.empty", 64'(emp1), 64'(q1.size() == 0));
      chk("m1.ovf", 64'(ovf1), 64'(mo1));
    end
  end

  task automatic step(input bit e, input bit b, input bit c,
                      input logic [3:0] d);
    cif.enter = e;
    cif.backspace = b;
    cif.clear = c;
    cif.digit = d;
    @(posedge clk);
    mdl_clk(e, b, c, int'(d));
    #2;
  endtask

  task automatic press(input bit e, input bit b, input bit c,
                       input logic [3:0] d);
    step(e, b, c, d);
    step(0, 0, 0, 4'h0);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    run = 0;
    reset_n = 1'b0;
    cif.enter = 0;
    cif.backspace = 0;
    cif.clear = 0;
    cif.digit = 4'h0;
    mdl_reset();
    #2;
    chk("rst.value", 64'(val0), 64'h0);
    chk("rst.count", 64'(cnt0), 64'h0);
    chk("rst.empty", 64'(emp0), 64'h1);
    chk("rst.full", 64'(full0), 64'h0);
    chk("rst.ovf", 64'(ovf0), 64'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    run = 1;

    for (int i = 1; i <= 3; i++) press(1, 0, 0, 4'(i));
    chk("e123.value", 64'(val0), 64'h123);
    chk("e123.count", 64'(cnt0), 64'd3);
    chk("e123.empty", 64'(emp0), 64'h0);
    chk("e123.full", 64'(full0), 64'h0);

    press(0, 1, 0, 4'h0);
    press(0, 1, 0, 4'h0);
    chk("bs2.value", 64'(val0), 64'h1);
    press(1, 1, 0, 4'h7);
    chk("eb.value", 64'(val0), 64'h17);
    chk("eb.count", 64'(cnt0), 64'd2);

    press(0, 0, 1, 4'h0);
    press(1, 0, 0, 4'h4);
    press(1, 0, 0, 4'h5);
    chk("e45.value", 64'(val0), 64'h45);
    press(1, 1, 1, 4'h9);
    chk("ceb.value", 64'(val0), 64'h0);
    chk("ceb.count", 64'(cnt0), 64'd0);
    press(0, 1, 0, 4'h0);
    chk("bsempty.value", 64'(val0), 64'h0);
    chk("bsempty.count", 64'(cnt0), 64'd0);
    chk("bsempty.ovf", 64'(ovf0), 64'h0);

    for (int i = 1; i <= 8; i++) press(1, 0, 0, 4'(i));
    chk("f8.full", 64'(full0), 64'h1);
    chk("f8.value", 64'(val0), 64'h12345678);
    step(1, 0, 0, 4'h9);
    chk("drop.value", 64'(val0), 64'h23456789);
    chk("drop.count", 64'(cnt0), 64'd8);
    chk("drop.ovf", 64'(ovf0), 64'h1);
    chk("rej.value", 64'(val1), 64'h12345678);
    chk("rej.count", 64'(cnt1), 64'd8);
    chk("rej.ovf", 64'(ovf1), 64'h1);
    step(0, 0, 0, 4'h0);
    chk("drop.ovf_off", 64'(ovf0), 64'h0);
    chk("rej.ovf_off", 64'(ovf1), 64'h0);
    chk("drop.full", 64'(full0), 64'h1);

    press(0, 0, 1, 4'h0);
    for (int i = 1; i <= 5; i++) press(1, 0, 0, 4'(i));
    chk("c5.count", 64'(cnt0), 64'd5);
    reset_n = 1'b0;
    #1;
    mdl_reset();
    chk("arst.value", 64'(val0), 64'h0);
    chk("arst.count", 64'(cnt0), 64'd0);
    chk("arst.empty", 64'(emp0), 64'h1);
    chk("arst.full", 64'(full0), 64'h0);
    chk("arst.ovf", 64'(ovf0), 64'h0);
    #1;
    reset_n = 1'b1;

    press(1, 0, 0, 4'h6);
    chk("first.value", 64'(val0), 64'h6);
    chk("first.count", 64'(cnt0), 64'd1);

    for (int i = 0; i < 4; i++) step(1, 0, 0, 4'h2);
    step(0, 0, 0, 4'h0);
`ifdef DIGIT_ENTRY_EDGE_EN
    chk("hold.count", 64'(cnt0), 64'd2);
    chk("hold.value", 64'(val0), 64'h62);
`else
    chk("hold.count", 64'(cnt0), 64'd5);
    chk("hold.value", 64'(val0), 64'h62222);
`endif

    for (int i = 0; i < 24; i++)
      step(i % 3 != 2, i % 5 == 1, i == 13, 4'(i));
    for (int i = 0; i < 12; i++)
      step(1'b1, i % 4 == 3, 1'b0, 4'(15 - i));
    step(0, 0, 0, 4'h0);

    @(negedge clk);
    #1;
    run = 0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
